rf_tag_alloc: RTL and testbench
===============================

# rf_tag_alloc

Tag allocator for the register-file renaming tags. It hands out up to four 6-bit tags per cycle to the issue slots that drive the register file's tag ports (tag1..tag4 / T1..T4) and reclaims up to two tags per cycle from the writeback ports (write1/write2 with Writer1Tag/Writer2Tag). Tag value 0 means "register ready" and is never allocated, so the pool is tags 1..63. The block sits between decode/issue and the register file, and stalls issue when the pool cannot satisfy a full group.

## Interface
- NTAG, 64: tag space size, with tag 0 reserved. Fixed for 6-bit tags.
- NSLOT, 4: issue slots per cycle.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; returns every tag to the pool.
- alloc_req  in  4  per-slot tag requests. Slot 1 is bit 0. The pattern must be contiguous from bit 0.
- alloc_gnt  out  4  grant. It is either equal to alloc_req or 0.
- alloc_tag1..alloc_tag4  out  6 each  tag for each slot. Valid when the matching alloc_gnt bit is set.
- stall  out  1  alloc_req is nonzero and not granted.
- rel1, rel2  in  1 each  tag release strobes, aligned with RF write1/write2.
- rel_tag1, rel_tag2  in  6 each  tags being released.
- free_cnt  out  7  number of free tags, 0..63.
- err  out  1  sticky error flag (see Configuration).

## Operation
- State is the free bitmap free_map[63:1], where 1 means free, plus the registered free_cnt.
- **Candidate selection:**
  - alloc_tag1 is the lowest free tag.
  - alloc_tag2 is the next lowest, and so on up to alloc_tag4.
  - Selection is combinational from the registered free_map.
  - Unused tag outputs show the candidate anyway.
  - If fewer than four tags are free, missing candidates read 0.
- **Grant, all-or-nothing to keep issue in order:**
  - Let n = popcount(alloc_req).
  - If n ≤ free_cnt and the request is legal, then alloc_gnt = alloc_req.
  - Otherwise alloc_gnt = 0 and stall = 1.
- **Legal requests** are 0000, 0001, 0011, 0111 and 1111. Any other pattern is ungranted; no tags are consumed.
- **Edge update when flush = 0:**
  - Granted tags are cleared in free_map.
  - rel_tag1 and rel_tag2 are set in free_map when rel1 and rel2 are asserted.
  - free_cnt_next = free_cnt − n_granted + n_released.
- A tag released in cycle k is not allocatable until cycle k+1. There is no same-cycle bypass.
- Releasing tag 0 is ignored and does not change free_cnt.
- rel1 and rel2 naming the same tag count as one release.
- **Flush:**
  - At the edge, free_map becomes all ones and free_cnt becomes 63.
  - Grants and releases in the flush cycle are discarded.
  - alloc_gnt is forced to 0 during flush.
  - Upstream guarantees that no pre-flush tag is released after flush.
- **Reset:**
  - free_map is all ones and free_cnt = 63.
  - err = 0.
  - Outputs immediately after reset:
    - alloc_tag1..4 = 1, 2, 3, 4.
    - alloc_gnt = 0 and stall = 0, with alloc_req = 0.
  - Reset in the middle of operation discards all allocations.

## Timing
- Grant latency is 0 cycles: alloc_gnt and alloc_tagN are valid in the same cycle as alloc_req. The issue stage registers them along with T1..T4.
- Release latency is 1 cycle before the tag can be reallocated.
- free_cnt is registered and reflects the state after the previous edge.
- Allocation and release in the same cycle both apply. The count arithmetic is done at 7 bits and never wraps, because of the legal-use invariants.
- Empty pool (free_cnt = 0): any nonzero request stalls. A release makes the tag grantable on the next cycle.
- Full pool (free_cnt = 63): a further release is a double-free, and is flagged when checking is enabled.

## Configuration
- Macro: RF_TAG_ALLOC_CHECK_EN.
- **Defined:** err is set at the edge, and held until reset, when any of these occurs:
  - a release of an already-free tag;
  - a release of tag 0;
  - a non-contiguous alloc_req;
  - free_cnt != popcount(free_map).
- **Undefined:** err is tied to 0 and none of the checking logic is built. Functional behaviour is otherwise identical.

## Structure
- Shared package holds:
  - TAG_W = 6, NTAG = 64, NSLOT = 4;
  - the tag_t typedef;
  - the localparam TAG_NONE = 0 (ready encoding shared with the register file).
- One sub-module: rf_tag_pick. It finds the lowest set bit of a 63-bit vector and returns the tag plus a found flag. It is instantiated four times in a chain, each masking the previous pick.

## Test plan
- **Reset:** assert reset = 0 mid-run, then release it.
  - Expect free_cnt = 63, alloc_tag1..4 = 1, 2, 3, 4, and err = 0.
- **Full-group allocation and exhaustion:** drive alloc_req = 1111 each cycle.
  - Expect tags 1–4, then 5–8, and so on.
  - After 15 grants free_cnt = 3, and the next 1111 gives stall = 1 and gnt = 0.
  - alloc_req = 0111 is then granted 61, 62, 63.
- **Release then reuse:** with the pool empty, rel1 = 1 with rel_tag1 = 9.
  - The same cycle's 0001 request stalls.
  - The next cycle grants tag 9, and free_cnt goes 1 → 0.
- **Simultaneous activity:** grant 0011 while releasing tags 2 and 7 (rel1 and rel2).
  - Expect free_cnt net 0 and the bitmap updated correctly.
  - With both releases naming tag 7, expect +1 only.
- **Flush:** with 20 tags allocated, assert flush together with req = 1111 and rel1.
  - Expect gnt = 0 that cycle, then free_cnt = 63 and tags 1–4 next cycle.
- **Checks (RF_TAG_ALLOC_CHECK_EN):**
  - Releasing a free tag sets err = 1, and it stays set.
  - alloc_req = 0101 gives gnt = 0, stall = 1 and err = 1.
  - Without the macro, err stays 0.

Source files
------------

// File: rtl/rf_tag_alloc_pkg.sv
// rf_tag_alloc_pkg: shared tag-space constants, tag type and popcount helper for the tag allocator
package rf_tag_alloc_pkg;
    localparam int TAG_W = 6;
    localparam int NTAG  = 64;
    localparam int NSLOT = 4;
    localparam int CNT_W = 7;
    typedef logic [TAG_W-1:0] tag_t;
    localparam tag_t TAG_NONE = '0;
    function automatic logic [CNT_W-1:0] count_ones(input logic [NTAG-1:0] v);
        count_ones = '0;
        for (int i = 0; i < NTAG; i++) count_ones = count_ones + CNT_W'(v[i]);
    endfunction
endpackage

// File: rtl/rf_tag_pick.sv
// rf_tag_pick: lowest set bit of a tag bitmap (bit 0 absent), tag 0 when empty
module rf_tag_pick
    import rf_tag_alloc_pkg::*;
(
    input  logic [NTAG-1:1] vec,
    output tag_t            tag,
    output logic            found
);
    always_comb begin
        tag = TAG_NONE;
        for (int i = NTAG - 1; i >= 1; i--) if (vec[i]) tag = tag_t'(i);
    end
    assign found = |vec;
endmodule

// File: rtl/rf_tag_alloc.sv
// rf_tag_alloc: hands out up to four rename tags per cycle and reclaims up to two.
// Optional checker enabled by RF_TAG_ALLOC_CHECK_EN drives the sticky err flag.
module rf_tag_alloc
    import rf_tag_alloc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [NSLOT-1:0] alloc_req,
    output logic [NSLOT-1:0] alloc_gnt,
    output tag_t             alloc_tag1,
    output tag_t             alloc_tag2,
    output tag_t             alloc_tag3,
    output tag_t             alloc_tag4,
    output logic             stall,
    input  logic             rel1,
    input  logic             rel2,
    input  tag_t             rel_tag1,
    input  tag_t             rel_tag2,
    output logic [CNT_W-1:0] free_cnt,
    output logic             err
);
    logic [NTAG-1:1]              free_map;
    logic [NTAG-1:1]              nxt_map;
    logic [NSLOT-1:0][NTAG-1:1]   mask;
    tag_t [NSLOT-1:0]             cand;
    logic [NSLOT-1:0]             found;
    logic [CNT_W-1:0]             n_req;
    logic [CNT_W-1:0]             cnt_nxt;
    logic                         legal;
    logic                         grant_ok;
    logic                         r1;
    logic                         r2;

    // each stage sees the previous stage's bitmap with its lowest free tag removed
    genvar g;
    for (g = 0; g < NSLOT; g++) begin : g_pick
        if (g == 0) begin : g_head
            assign mask[g] = free_map;
        end else begin : g_link
            assign mask[g] = mask[g-1] & (mask[g-1] - 1'b1);
        end
        rf_tag_pick u_pick (.vec(mask[g]), .tag(cand[g]), .found(found[g]));
    end

    assign alloc_tag1 = cand[0];
    assign alloc_tag2 = cand[1];
    assign alloc_tag3 = cand[2];
    assign alloc_tag4 = cand[3];

    assign legal     = alloc_req inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    assign n_req     = count_ones(NTAG'(alloc_req));
    assign grant_ok  = !flush && legal && (n_req <= free_cnt);
    assign alloc_gnt = grant_ok ? alloc_req : '0;
    assign stall     = (|alloc_req) && !grant_ok;

    assign r1 = rel1 && (rel_tag1 != TAG_NONE);
    assign r2 = rel2 && (rel_tag2 != TAG_NONE) && !(r1 && (rel_tag2 == rel_tag1));

    always_comb begin
        nxt_map = free_map;
        for (int i = 0; i < NSLOT; i++) if (alloc_gnt[i] && found[i]) nxt_map[cand[i]] = 1'b0;
        if (r1) nxt_map[rel_tag1] = 1'b1;
        if (r2) nxt_map[rel_tag2] = 1'b1;
    end

    assign cnt_nxt = free_cnt - (grant_ok ? n_req : '0) + CNT_W'(r1) + CNT_W'(r2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_map <= '1;
            free_cnt <= CNT_W'(NTAG - 1);
        end else if (flush) begin
            free_map <= '1;
            free_cnt <= CNT_W'(NTAG - 1);
        end else begin
            free_map <= nxt_map;
            free_cnt <= cnt_nxt;
        end
    end

`ifdef RF_TAG_ALLOC_CHECK_EN
    logic err_set;
    logic err_q;
    assign err_set = (rel1 && (rel_tag1 == TAG_NONE || free_map[rel_tag1]))
                  || (rel2 && (rel_tag2 == TAG_NONE || free_map[rel_tag2]))
                  || !legal
                  || (free_cnt != count_ones({free_map, 1'b0}));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rf_tag_alloc.sv
// tb_rf_tag_alloc: directed vectors with a queue scoreboard checked by an independent monitor
module tb_rf_tag_alloc;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] alloc_req = '0;
    logic [3:0] alloc_gnt;
    logic [5:0] alloc_tag1, alloc_tag2, alloc_tag3, alloc_tag4;
    logic       stall;
    logic       rel1 = 1'b0, rel2 = 1'b0;
    logic [5:0] rel_tag1 = '0, rel_tag2 = '0;
    logic [6:0] free_cnt;
    logic       err;

`ifdef RF_TAG_ALLOC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  gnt;
        logic        stall;
        logic [23:0] tags;
        logic [7:0]  cnt;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    rf_tag_alloc dut (
        .clk(clk), .reset(reset), .flush(flush), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2), .alloc_tag3(alloc_tag3),
        .alloc_tag4(alloc_tag4), .stall(stall), .rel1(rel1), .rel2(rel2),
        .rel_tag1(rel_tag1), .rel_tag2(rel_tag2), .free_cnt(free_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            chk("gnt", vectors, 32'(alloc_gnt), 32'(e.gnt));
            chk("stall", vectors, 32'(stall), 32'(e.stall));
            chk("tags", vectors, 32'({alloc_tag4, alloc_tag3, alloc_tag2, alloc_tag1}), 32'(e.tags));
            if (e.cnt != 8'hFF) chk("free_cnt", vectors, 32'(free_cnt), 32'(e.cnt));
            chk("err", vectors, 32'(err), 32'(e.err));
        end
    end

    task automatic step(input logic [3:0] req, input logic fl, input logic ra, input logic [5:0] ta,
                        input logic rb, input logic [5:0] tb, input logic [3:0] g, input logic s,
                        input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d,
                        input logic [7:0] cnt, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        alloc_req = req; flush = fl; rel1 = ra; rel_tag1 = ta; rel2 = rb; rel_tag2 = tb;
        e.gnt = g; e.stall = s; e.tags = {d, c, b, a}; e.cnt = cnt; e.err = er;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; alloc_req = '0; flush = 1'b0; rel1 = 1'b0; rel2 = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, 0);
        for (int k = 0; k < 15; k++)
            step(4'hF, 0, 0, 0, 0, 0, 4'hF, 0, 6'(4*k+1), 6'(4*k+2), 6'(4*k+3), 6'(4*k+4), 8'(63-4*k), 0);
        step(4'hF, 0, 0, 0, 0, 0, 4'h0, 1, 61, 62, 63, 0, 3, 0);
        step(4'h7, 0, 0, 0, 0, 0, 4'h7, 0, 61, 62, 63, 0, 3, 0);
        step(4'h1, 0, 1, 9, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 0);
        step(4'h1, 0, 0, 0, 0, 0, 4'h1, 0, 9, 0, 0, 0, 1, 0);
        step(4'h0, 0, 1, 10, 1, 20, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        step(4'h3, 0, 1, 2, 1, 7, 4'h3, 0, 10, 20, 0, 0, 2, 0);
        step(4'h0, 0, 1, 30, 1, 30, 4'h0, 0, 2, 7, 0, 0, 2, 0);
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 2, 7, 30, 0, 3, 0);
        do_reset();
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, 0);
        for (int k = 0; k < 5; k++)
            step(4'hF, 0, 0, 0, 0, 0, 4'hF, 0, 6'(4*k+1), 6'(4*k+2), 6'(4*k+3), 6'(4*k+4), 8'(63-4*k), 0);
        step(4'hF, 1, 1, 3, 0, 0, 4'h0, 1, 21, 22, 23, 24, 43, 0);
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, 0);
        step(4'h5, 0, 0, 0, 0, 0, 4'h0, 1, 1, 2, 3, 4, 63, 0);
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, CHK);
        step(4'h0, 0, 1, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, CHK);
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, CHK);
        do_reset();
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, 0);
        step(4'h0, 0, 1, 5, 0, 0, 4'h0, 0, 1, 2, 3, 4, 63, 0);
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 8'hFF, CHK);
        step(4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 2, 3, 4, 8'hFF, CHK);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
